// File: rtl/dp_seq_pkg.sv
// Shared types and instruction-field helpers for the dp_seq_ctrl sequencer.
// Instruction layout, MSB first: class[1:0], op/cond[2:0], rd, ra, rb (M bits each), imm[N-1:0].
// Optional retire counter is enabled by defining DP_SEQ_CTRL_RETIRE_CNT_EN.
package dp_seq_pkg;

    // Sequencer states; exported on the top-level debug port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Instruction classes.
    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_ALUI = 2'b01;
    localparam logic [1:0] CLS_LDI  = 2'b10;
    localparam logic [1:0] CLS_CTL  = 2'b11;

    // Condition codes for class 11.
    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_N      = 3'b010;
    localparam logic [2:0] COND_O      = 3'b011;
    localparam logic [2:0] COND_NZ     = 3'b100;
    localparam logic [2:0] COND_NOP5   = 3'b101;
    localparam logic [2:0] COND_NOP6   = 3'b110;
    localparam logic [2:0] COND_HALT   = 3'b111;

    // One-bit datapath strobes, grouped so the decoder drives them as one value.
    typedef struct packed {
        logic ie;
        logic write;
        logic reada;
        logic readb;
        logic en;
        logic oe;
        logic bypassa;
        logic bypassb;
    } strobe_t;

    // Instruction width for a given register-address width m and data width n.
    function automatic int f_iw(input int m, input int n);
        return 5 + 3 * m + n;
    endfunction

    // LSB positions of each instruction field.
    function automatic int f_cls_lsb(input int m, input int n);
        return f_iw(m, n) - 2;
    endfunction

    function automatic int f_op_lsb(input int m, input int n);
        return f_iw(m, n) - 5;
    endfunction

    function automatic int f_rd_lsb(input int m, input int n);
        return f_iw(m, n) - 5 - m;
    endfunction

    function automatic int f_ra_lsb(input int m, input int n);
        return f_iw(m, n) - 5 - 2 * m;
    endfunction

    function automatic int f_rb_lsb(input int m, input int n);
        return f_iw(m, n) - 5 - 3 * m;
    endfunction

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational decoder: turns the latched instruction and the current
// sequencer state into datapath strobes, addresses, op and immediates.
// Everything here depends only on registered values, so outputs are Moore
// and never follow the instruction-memory bus. Unused fields are driven to 0.
module dp_seq_decode
    import dp_seq_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 8,
    localparam int IW = f_iw(M, N)
) (
    input  state_t        i_state,
    input  logic [IW-1:0] i_instr,
    output strobe_t       o_strb,
    output logic [N-1:0]  o_din,
    output logic [N-1:0]  o_offset,
    output logic [2:0]    o_op,
    output logic [M-1:0]  o_waddr,
    output logic [M-1:0]  o_ra,
    output logic [M-1:0]  o_rb,
    output logic [1:0]    o_cls,
    output logic [2:0]    o_cond,
    output logic [N-1:0]  o_imm
);

    localparam int CLS_LSB = f_cls_lsb(M, N);
    localparam int OP_LSB  = f_op_lsb(M, N);
    localparam int RD_LSB  = f_rd_lsb(M, N);
    localparam int RA_LSB  = f_ra_lsb(M, N);
    localparam int RB_LSB  = f_rb_lsb(M, N);

    logic [1:0]   w_cls;
    logic [2:0]   w_op;
    logic [M-1:0] w_rd;
    logic [M-1:0] w_ra;
    logic [M-1:0] w_rb;
    logic [N-1:0] w_imm;
    logic         w_is_alu;

    assign w_cls    = i_instr[CLS_LSB +: 2];
    assign w_op     = i_instr[OP_LSB +: 3];
    assign w_rd     = i_instr[RD_LSB +: M];
    assign w_ra     = i_instr[RA_LSB +: M];
    assign w_rb     = i_instr[RB_LSB +: M];
    assign w_imm    = i_instr[N-1:0];
    assign w_is_alu = (w_cls == CLS_ALU) || (w_cls == CLS_ALUI);

    // Raw fields the FSM needs for sequencing and branch resolution.
    assign o_cls  = w_cls;
    assign o_cond = w_op;
    assign o_imm  = w_imm;

    // Per-state strobe generation; ALU operands are held through EXEC so the
    // registered ALU sees stable inputs, and the result is written in WB.
    always_comb begin
        o_strb   = '0;
        o_din    = '0;
        o_offset = '0;
        o_op     = '0;
        o_waddr  = '0;
        o_ra     = '0;
        o_rb     = '0;
        case (i_state)
            ST_DECODE, ST_EXEC: begin
                if (w_is_alu) begin
                    o_strb.readb = 1'b1;
                    o_rb         = w_rb;
                    if (w_cls == CLS_ALU) begin
                        o_strb.reada = 1'b1;
                        o_ra         = w_ra;
                    end else begin
                        o_strb.bypassa = 1'b1;
                        o_offset       = w_imm;
                    end
                    if (i_state == ST_EXEC) begin
                        o_strb.en = 1'b1;
                        o_op      = w_op;
                    end
                end
            end
            ST_WB: begin
                o_strb.write = 1'b1;
                o_waddr      = w_rd;
                if (w_cls == CLS_LDI) begin
                    o_strb.ie = 1'b1;
                    o_din     = w_imm;
                end else begin
                    o_strb.oe = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dp_seq_ctrl.sv
// Fetch/decode/execute sequencer for the register-file + registered-ALU datapath.
// Owns the FSM, program counter and instruction register; datapath controls come
// from dp_seq_decode. Define DP_SEQ_CTRL_RETIRE_CNT_EN to add the 16-bit
// retire_cnt output counting completed instructions.
// imem handshake: imem_req is high for the whole FETCH state with imem_addr held
// at pc; a single-cycle imem_ack with imem_req high transfers imem_rdata.
module dp_seq_ctrl
    import dp_seq_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 8,
    localparam int IW = f_iw(M, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          halted,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          imem_ack,
    output logic [N-1:0]  dp_din,
    output logic [M-1:0]  dp_waddr,
    output logic [M-1:0]  dp_ra,
    output logic [M-1:0]  dp_rb,
    output logic [2:0]    dp_op,
    output logic [N-1:0]  dp_offset,
    output logic          dp_ie,
    output logic          dp_write,
    output logic          dp_reada,
    output logic          dp_readb,
    output logic          dp_en,
    output logic          dp_oe,
    output logic          dp_bypassa,
    output logic          dp_bypassb,
    input  logic          o_flag,
    input  logic          z_flag,
    input  logic          n_flag,
    output state_t        o_dbg_state
`ifdef DP_SEQ_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0]   retire_cnt
`endif
);

    state_t        r_state;
    logic [N-1:0]  r_pc;
    logic [IW-1:0] r_instr;

    strobe_t       w_strb;
    logic [1:0]    w_cls;
    logic [2:0]    w_cond;
    logic [N-1:0]  w_imm;
    logic          w_taken;

    dp_seq_decode #(
        .M (M),
        .N (N)
    ) u_decode (
        .i_state  (r_state),
        .i_instr  (r_instr),
        .o_strb   (w_strb),
        .o_din    (dp_din),
        .o_offset (dp_offset),
        .o_op     (dp_op),
        .o_waddr  (dp_waddr),
        .o_ra     (dp_ra),
        .o_rb     (dp_rb),
        .o_cls    (w_cls),
        .o_cond   (w_cond),
        .o_imm    (w_imm)
    );

    // Branch condition against the flags present during DECODE.
    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            COND_ALWAYS: w_taken = 1'b1;
            COND_Z:      w_taken = z_flag;
            COND_N:      w_taken = n_flag;
            COND_O:      w_taken = o_flag;
            COND_NZ:     w_taken = ~z_flag;
            default:     w_taken = 1'b0;
        endcase
    end

    // Sequencer FSM with program counter and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_pc    <= r_pc + N'(1);
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_cls)
                        CLS_ALU, CLS_ALUI: r_state <= ST_EXEC;
                        CLS_LDI:           r_state <= ST_WB;
                        default: begin
                            if (w_cond == COND_HALT) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_FETCH;
                                if (w_taken) r_pc <= w_imm;
                            end
                        end
                    endcase
                end
                ST_EXEC: r_state <= ST_WB;
                ST_WB:   r_state <= ST_FETCH;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the registered state; the
    // async reset clears them in the same cycle.
    assign halted      = (r_state == ST_IDLE);
    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign o_dbg_state = r_state;

    assign dp_ie      = w_strb.ie;
    assign dp_write   = w_strb.write;
    assign dp_reada   = w_strb.reada;
    assign dp_readb   = w_strb.readb;
    assign dp_en      = w_strb.en;
    assign dp_oe      = w_strb.oe;
    assign dp_bypassa = w_strb.bypassa;
    assign dp_bypassb = w_strb.bypassb;

`ifdef DP_SEQ_CTRL_RETIRE_CNT_EN
    logic [15:0] r_retire;

    // Count instructions leaving WB or a control-class DECODE (HALT included).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire <= '0;
        end else if ((r_state == ST_WB) ||
                     ((r_state == ST_DECODE) && (w_cls == CLS_CTL))) begin
            r_retire <= r_retire + 16'd1;
        end
    end

    assign retire_cnt = r_retire;
`endif

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Bench for dp_seq_ctrl: acts as instruction memory and flag source, predicts
// each cycle's control outputs from the instruction-class table, and compares.
`timescale 1ns/1ps
module tb_dp_seq_ctrl;
  import dp_seq_pkg::*;

  localparam int M  = 3;
  localparam int N  = 8;
  localparam int IW = 5 + 3 * M + N;

  // Observable control bundle, one value per cycle.
  typedef struct packed {
    logic req, hlt, ie, wr, rda, rdb, en, oe, bpa, bpb;
    logic [N-1:0] din;
    logic [N-1:0] off;
    logic [2:0]   op;
    logic [M-1:0] wa;
    logic [M-1:0] ra;
    logic [M-1:0] rb;
  } bnd_t;
  localparam int BW = $bits(bnd_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, start, imem_ack, o_flag, z_flag, n_flag;
  logic halted, imem_req;
  logic [N-1:0] imem_addr, dp_din, dp_offset;
  logic [IW-1:0] imem_rdata;
  logic [M-1:0] dp_waddr, dp_ra, dp_rb;
  logic [2:0] dp_op;
  logic dp_ie, dp_write, dp_reada, dp_readb, dp_en, dp_oe, dp_bypassa, dp_bypassb;
  state_t dbg_state;
`ifdef DP_SEQ_CTRL_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  dp_seq_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dp_din(dp_din), .dp_waddr(dp_waddr), .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_op(dp_op),
    .dp_offset(dp_offset), .dp_ie(dp_ie), .dp_write(dp_write), .dp_reada(dp_reada),
    .dp_readb(dp_readb), .dp_en(dp_en), .dp_oe(dp_oe), .dp_bypassa(dp_bypassa),
    .dp_bypassb(dp_bypassb), .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag),
    .o_dbg_state(dbg_state)
`ifdef DP_SEQ_CTRL_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  bnd_t obs;
  always_comb begin
    obs = '0;
    obs.req = imem_req;   obs.hlt = halted;    obs.ie  = dp_ie;     obs.wr  = dp_write;
    obs.rda = dp_reada;   obs.rdb = dp_readb;  obs.en  = dp_en;     obs.oe  = dp_oe;
    obs.bpa = dp_bypassa; obs.bpb = dp_bypassb;
    obs.din = dp_din;     obs.off = dp_offset; obs.op  = dp_op;
    obs.wa  = dp_waddr;   obs.ra  = dp_ra;     obs.rb  = dp_rb;
  end

  // ---------------- scoreboard / model state ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] m_pc;
  logic [15:0]  m_retire;
  logic         m_halted;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic chk_retire();
`ifdef DP_SEQ_CTRL_RETIRE_CNT_EN
    chk("retire_cnt", 64'(retire_cnt), 64'(m_retire));
`endif
  endtask

  function automatic bnd_t e_idle();
    bnd_t b;
    b = '0;
    b.hlt = 1'b1;
    return b;
  endfunction

  function automatic bnd_t e_fetch();
    bnd_t b;
    b = '0;
    b.req = 1'b1;
    return b;
  endfunction

  function automatic logic [IW-1:0] mk(input logic [1:0] c, input logic [2:0] o,
                                       input logic [M-1:0] d, input logic [M-1:0] a,
                                       input logic [M-1:0] b, input logic [N-1:0] im);
    return {c, o, d, a, b, im};
  endfunction

  // ---------------- driver tasks ----------------
  // Each task starts and ends at a falling edge; inputs change only there.
  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) begin
      chk("idle_bus", 64'(obs), 64'(e_idle()));
      chk("idle_addr", 64'(imem_addr), 64'(m_pc));
      chk("idle_state", 64'(dbg_state), 64'(ST_IDLE));
      chk_retire();
      @(negedge clk);
    end
  endtask

  task automatic kick();
    chk("kick_bus", 64'(obs), 64'(e_idle()));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Fetch one instruction after dly wait cycles, then follow it to completion.
  // rst_at >= 0 asserts reset during that post-fetch cycle (1 = EXEC for ALU).
  task automatic run_instr(input logic [IW-1:0] iw, input int dly,
                           input logic [2:0] onz, input int rst_at);
    logic [1:0]   f_cls;
    logic [2:0]   f_op;
    logic [M-1:0] f_rd, f_ra, f_rb;
    logic [N-1:0] f_imm;
    bnd_t         b;
    logic         taken;
    int           i;
    {f_cls, f_op, f_rd, f_ra, f_rb, f_imm} = iw;
    for (int k = 0; k <= dly; k++) begin
      chk("fetch_bus", 64'(obs), 64'(e_fetch()));
      chk("fetch_addr", 64'(imem_addr), 64'(m_pc));
      if (k == 0) chk_retire();
      start      = ($urandom_range(0, 3) == 0);
      imem_ack   = (k == dly);
      imem_rdata = (k == dly) ? iw : IW'($urandom);
      {o_flag, n_flag, z_flag} = (k == dly) ? onz : 3'($urandom);
      @(negedge clk);
    end
    imem_ack   = 1'b0;
    imem_rdata = IW'($urandom);
    m_pc       = m_pc + 8'd1;

    // Expected per-cycle outputs from the instruction-class table.
    case (f_cls)
      CLS_ALU, CLS_ALUI: begin
        b = '0;
        b.rdb = 1'b1; b.rb = f_rb;
        if (f_cls == CLS_ALU) begin b.rda = 1'b1; b.ra = f_ra; end
        else begin b.bpa = 1'b1; b.off = f_imm; end
        exp_q.push_back(b);                 // DECODE
        b.en = 1'b1; b.op = f_op;
        exp_q.push_back(b);                 // EXEC
        b = '0; b.wr = 1'b1; b.oe = 1'b1; b.wa = f_rd;
        exp_q.push_back(b);                 // WB
      end
      CLS_LDI: begin
        exp_q.push_back('0);                // DECODE
        b = '0; b.ie = 1'b1; b.din = f_imm; b.wr = 1'b1; b.wa = f_rd;
        exp_q.push_back(b);                 // WB
      end
      default: exp_q.push_back('0);         // DECODE of control
    endcase

    i = 0;
    while (exp_q.size() > 0) begin
      b = bnd_t'(exp_q.pop_front());
      chk($sformatf("cyc%0d_cls%0d", i, f_cls), 64'(obs), 64'(b));
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        m_pc = '0;
        m_retire = '0;
        chk("rst_bus", 64'(obs), 64'(e_idle()));
        chk("rst_addr", 64'(imem_addr), 64'(m_pc));
        chk_retire();
        exp_q.delete();
        @(negedge clk);
        chk("rst_hold_bus", 64'(obs), 64'(e_idle()));
        rst = 1'b0;
        return;
      end
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      i++;
    end

    m_retire = m_retire + 16'd1;
    if (f_cls == CLS_CTL) begin
      case (f_op)
        3'd0:    taken = 1'b1;
        3'd1:    taken = onz[0];
        3'd2:    taken = onz[1];
        3'd3:    taken = onz[2];
        3'd4:    taken = ~onz[0];
        default: taken = 1'b0;
      endcase
      if (f_op == 3'd7) m_halted = 1'b1;
      else if (taken) m_pc = f_imm;
    end
  endtask

  task automatic resume_if_halted();
    if (m_halted) begin
      idle_cycles($urandom_range(1, 3));
      kick();
      m_halted = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    o_flag = 1'b0; z_flag = 1'b0; n_flag = 1'b0;
    m_pc = '0; m_retire = '0; m_halted = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_bus", 64'(obs), 64'(e_idle()));
    chk("reset_addr", 64'(imem_addr), 64'(0));
    chk_retire();
    rst = 1'b0;
    idle_cycles(2);
    kick();

    // LDI r2,#0x5A with three request cycles, then ALU-reg and ALU-imm.
    run_instr(mk(CLS_LDI, 3'd0, 3'd2, 3'd0, 3'd0, 8'h5A), 2, 3'b000, -1);
    run_instr(mk(CLS_ALU, 3'b010, 3'd3, 3'd1, 3'd2, 8'h77), 0, 3'b000, -1);
    run_instr(mk(CLS_ALUI, 3'b001, 3'd5, 3'd6, 3'd4, 8'h10), 1, 3'b000, -1);

    // Conditional jumps: each condition both taken and not taken.
    run_instr(mk(CLS_CTL, COND_Z, 3'd0, 3'd0, 3'd0, 8'h40), 0, 3'b001, -1);
    run_instr(mk(CLS_CTL, COND_Z, 3'd0, 3'd0, 3'd0, 8'h90), 0, 3'b110, -1);
    run_instr(mk(CLS_CTL, COND_N, 3'd0, 3'd0, 3'd0, 8'h20), 1, 3'b010, -1);
    run_instr(mk(CLS_CTL, COND_N, 3'd0, 3'd0, 3'd0, 8'h30), 0, 3'b101, -1);
    run_instr(mk(CLS_CTL, COND_O, 3'd0, 3'd0, 3'd0, 8'h50), 0, 3'b100, -1);
    run_instr(mk(CLS_CTL, COND_O, 3'd0, 3'd0, 3'd0, 8'h60), 0, 3'b011, -1);
    run_instr(mk(CLS_CTL, COND_NZ, 3'd0, 3'd0, 3'd0, 8'h70), 0, 3'b000, -1);
    run_instr(mk(CLS_CTL, COND_NZ, 3'd0, 3'd0, 3'd0, 8'h88), 0, 3'b001, -1);
    run_instr(mk(CLS_CTL, COND_NOP5, 3'd0, 3'd0, 3'd0, 8'h11), 0, 3'b111, -1);
    run_instr(mk(CLS_CTL, COND_NOP6, 3'd0, 3'd0, 3'd0, 8'h22), 0, 3'b111, -1);

    // pc wrap: jump to 0xFF, fetch there, next fetch must be at 0x00.
    run_instr(mk(CLS_CTL, COND_ALWAYS, 3'd0, 3'd0, 3'd0, 8'hFF), 0, 3'b000, -1);
    run_instr(mk(CLS_LDI, 3'd0, 3'd1, 3'd0, 3'd0, 8'h33), 0, 3'b000, -1);
    run_instr(mk(CLS_LDI, 3'd0, 3'd7, 3'd0, 3'd0, 8'hC3), 0, 3'b000, -1);

    // HALT, idle with start low, then resume at the following pc.
    run_instr(mk(CLS_CTL, COND_HALT, 3'd0, 3'd0, 3'd0, 8'h05), 1, 3'b111, -1);
    resume_if_halted();
    run_instr(mk(CLS_ALU, 3'b111, 3'd1, 3'd1, 3'd1, 8'h00), 0, 3'b000, -1);

    // Reset in EXEC of an ALU instruction, then restart from pc 0.
    run_instr(mk(CLS_ALU, 3'b011, 3'd6, 3'd2, 3'd5, 8'h00), 0, 3'b000, 1);
    m_halted = 1'b0;
    idle_cycles(2);
    kick();

    // Randomized instruction stream.
    repeat (300) begin
      run_instr(mk(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), 8'($urandom)),
                $urandom_range(0, 3), 3'($urandom), -1);
      resume_if_halted();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dp_seq_ctrl.md
Name: dp_seq_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer that drives every control input of the 3-address register-file + registered-ALU datapath.
- Fetches instruction words from an instruction memory over a req/ack handshake and decodes them into register addresses, ALU op, immediate, bypass and write-enable strobes.
- Evaluates conditional jumps from the datapath's o/z/n flags.
- Sits between imem and the datapath; top-level start/halted control.

Parameters:
- M, 3, register address width (2^M registers)
- N, 8, data width; also immediate width and PC width
- IW, derived localparam = 5+3*M+N, instruction width: [IW-1:IW-2] class, [IW-3:IW-5] op/cond, then rd, ra, rb (M bits each, MSB first), then imm[N-1:0]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; leaves IDLE and begins fetch at current pc
- halted  out  1  high in IDLE
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address (= pc)
- imem_rdata  in  IW  instruction word, valid when imem_ack=1
- imem_ack  in  1  one-cycle acknowledge
- dp_din  out  N  immediate to datapath din
- dp_waddr, dp_ra, dp_rb  out  M  register addresses
- dp_op  out  3  ALU op
- dp_offset  out  N  immediate for bypass path
- dp_ie, dp_write, dp_reada, dp_readb, dp_en, dp_oe, dp_bypassa, dp_bypassb  out  1  datapath strobes
- o_flag, z_flag, n_flag  in  1  datapath flags

Behaviour:
- Reset (async): state=IDLE, pc=0, instr reg=0, all outputs 0 except halted=1.
- States: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE: start=1 -> FETCH next cycle; start ignored elsewhere.
- FETCH: imem_req=1, imem_addr=pc held stable until imem_ack. On ack: latch imem_rdata, pc<=pc+1 (mod 2^N, wraps 2^N-1 -> 0), go DECODE. No timeout.
- Class 00 ALU-reg (rd <= ra op rb):
  - DECODE: reada=readb=1.
  - EXEC: reads held, en=1, op driven.
  - WB: write=1, waddr=rd, oe=1, ie=0.
- Class 01 ALU-imm (rd <= imm op rb): as class 00 but bypassa=1 and offset=imm in DECODE and EXEC; reada=0.
- Class 10 LDI (rd <= imm): DECODE -> WB directly. WB: ie=1, din=imm, write=1, waddr=rd; en=0.
- Class 11 control, evaluated in DECODE against flag inputs of that cycle:
  - cond 000 always, 001 z, 010 n, 011 o, 100 !z: if taken, pc<=imm.
  - 111 HALT -> IDLE, pc unchanged.
  - 101, 110 are NOPs.
  - All except HALT go DECODE -> FETCH.
- WB -> FETCH always. ALU latency is exactly 1 cycle (sum/flags valid in WB).
- Cycles per instruction, excluding fetch wait: ALU 3, LDI 2, control 1.
- Strobes are Moore outputs of state + latched instruction; never glitch on imem_rdata.
- dp_bypassb is always 0.
- din, offset, op, addresses are 0 when unused.
- Writing a register also read by the same instruction is legal: read precedes write.
- Reset mid-instruction aborts it; imem_req drops asynchronously; no register write occurs.

Optional Feature:
- DP_SEQ_CTRL_RETIRE_CNT_EN defined: adds output retire_cnt (16 bits), reset 0.
  - Increments by 1 on each WB exit and each class-11 DECODE exit, including HALT.
  - Wraps at 2^16.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package dp_seq_pkg: state enum; class codes CLS_ALU=2'b00, CLS_ALUI=2'b01, CLS_LDI=2'b10, CLS_CTL=2'b11; cond codes; field-offset localparams as functions of M, N.
- One sub-module natural: dp_seq_decode, purely combinational. Inputs: instruction + state. Outputs: strobe/addr/op vector. The FSM, pc and instruction register stay in dp_seq_ctrl.

Test Plan:
- Reset then start; imem_ack after 3 cycles on LDI r2,#0x5A -> imem_req high 3 cycles at addr 0; WB with ie=1, din=0x5A, waddr=2, write=1; pc=1.
- ALU-reg op=3'b010 rd=3 ra=1 rb=2, ack immediate -> reada/readb in DECODE, en=1 in EXEC, write=1/waddr=3/oe=1 in WB; 4 cycles fetch-to-fetch.
- ALU-imm imm=0x10 rb=4 -> bypassa=1, offset=0x10 in DECODE/EXEC; reada=0.
- z_flag=1: cond 001 imm=0x40 -> next imem_addr=0x40. z_flag=0: next imem_addr=pc+1. Repeat for n, o, !z.
- pc=0xFF fetch -> next imem_addr=0x00. HALT -> halted=1; start ignored until IDLE, then resume at pc.
- Assert rst during EXEC -> all strobes 0 same cycle, halted=1, pc=0, no write; with macro, retire_cnt=0.
